// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader uses the slave view; the host/driver uses the master view.
interface imem_loader_if #(
  parameter int ADDR_W = 7
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-terminated little-endian image
// into 32-bit instruction-memory writes and holds the CPU in reset until done.
module imem_loader #(
  parameter int DEPTH     = 128,
  parameter int ADDR_W    = 7,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         cpu_rst_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_req_t;

  state_t      state_q, state_n;
  logic [7:0]  cnt_lo_q, cnt_lo_n;
  logic [15:0] cnt_q, cnt_n;
  logic [15:0] word_idx_q, word_idx_n;
  logic [1:0]  byte_idx_q, byte_idx_n;
  logic [23:0] word_q, word_n;
  logic [7:0]  xor_q, xor_n;
  wr_req_t     wr_q, wr_n;
  logic        in_ready_q, in_ready_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;
  logic        error_q, error_n;
  logic        cpu_rst_q, cpu_rst_n_n;

  logic        xfer;
  logic        recv_n;
  logic [15:0] count;
  logic        last_word;

  // in_ready is a registered copy of "state is receiving", so it gates transfers directly.
  assign xfer      = bus.in_valid && in_ready_q;
  assign count     = {bus.in_data, cnt_lo_q};
  assign last_word = (word_idx_q == cnt_q - 16'd1);

  always_comb begin
    state_n     = state_q;
    cnt_lo_n    = cnt_lo_q;
    cnt_n       = cnt_q;
    word_idx_n  = word_idx_q;
    byte_idx_n  = byte_idx_q;
    word_n      = word_q;
    xor_n       = xor_q;
    wr_n        = wr_q;
    wr_n.en     = 1'b0;
    done_n      = done_q;
    error_n     = error_q;
    cpu_rst_n_n = cpu_rst_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n     = S_CNT_LO;
          done_n      = 1'b0;
          error_n     = 1'b0;
          cpu_rst_n_n = 1'b0;
          cnt_lo_n    = 8'd0;
          cnt_n       = 16'd0;
          word_idx_n  = 16'd0;
          byte_idx_n  = 2'd0;
          xor_n       = 8'd0;
        end
      end
      S_CNT_LO: begin
        if (xfer) begin
          cnt_lo_n = bus.in_data;
          state_n  = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (xfer) begin
          cnt_n = count;
          if (count > 16'(DEPTH)) begin
            state_n = S_ERR;
            error_n = 1'b1;
          end else if (count == 16'd0) begin
            state_n = S_CHK;
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          xor_n      = xor_q ^ bus.in_data;
          byte_idx_n = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: word_n[7:0]   = bus.in_data;
            2'd1: word_n[15:8]  = bus.in_data;
            2'd2: word_n[23:16] = bus.in_data;
            default: begin
              wr_n.en    = 1'b1;
              wr_n.addr  = word_idx_q[ADDR_W-1:0];
              wr_n.data  = {bus.in_data, word_q};
              word_idx_n = word_idx_q + 16'd1;
              if (last_word) state_n = S_CHK;
            end
          endcase
        end
      end
      S_CHK: begin
        if (xfer) begin
          if (bus.in_data == xor_q) begin
            state_n     = S_DONE;
            done_n      = 1'b1;
            cpu_rst_n_n = 1'b1;
          end else begin
            state_n = S_ERR;
            error_n = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    recv_n     = (state_n == S_CNT_LO) || (state_n == S_CNT_HI) ||
                 (state_n == S_DATA)   || (state_n == S_CHK);
    in_ready_n = recv_n;
    busy_n     = recv_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_lo_q   <= 8'd0;
      cnt_q      <= 16'd0;
      word_idx_q <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 24'd0;
      xor_q      <= 8'd0;
      wr_q       <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpu_rst_q  <= !BOOT_HOLD;
    end else begin
      state_q    <= state_n;
      cnt_lo_q   <= cnt_lo_n;
      cnt_q      <= cnt_n;
      word_idx_q <= word_idx_n;
      byte_idx_q <= byte_idx_n;
      word_q     <= word_n;
      xor_q      <= xor_n;
      wr_q       <= wr_n;
      in_ready_q <= in_ready_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      error_q    <= error_n;
      cpu_rst_q  <= cpu_rst_n_n;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_q.en;
  assign bus.wr_addr  = wr_q.addr;
  assign bus.wr_data  = wr_q.data;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign cpu_rst_n    = cpu_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: randomized images, gaps, bad checksums,
// over-counts and mid-load reset, with write timing checked by a monitor.
module tb_imem_loader;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic busy, done, error, cpu_rst_n;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BOOT_HOLD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    int                c;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] img[$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the next expected write and its cycle.
  always @(negedge clk) begin
    if (rst_n && bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=%h data=%h required none", bus.wr_addr, bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.a));
        chk("wr_data", bus.wr_data, e.d);
        chk("wr_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse, output int xc);
    int  t;
    bit  rdy;
    for (int g = 0; g < gap; g++) begin
      start = pulse && (g == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    t = 0;
    forever begin
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      t++;
      if (t > 50) begin
        checks++;
        failures++;
        $display("FAIL xfer_timeout actual=no_ready required=ready byte=%h", b);
        break;
      end
    end
    xc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(bus.in_ready), 1);
    chk("start_cpu_rst", 32'(cpu_rst_n), 0);
    chk("start_done", 32'(done), 0);
    chk("start_error", 32'(error), 0);
  endtask

  function automatic int pick_gap(input int maxgap, input bit need);
    int g;
    g = (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
    if (need && g == 0) g = 1;
    return g;
  endfunction

  // Model: the image is img[]; writes and checksum derive from stream rules directly.
  task automatic run_load(input int n_hdr, input logic [7:0] flip, input int maxgap, input bit bstart);
    logic [7:0] x;
    logic [7:0] b;
    logic [15:0] n16;
    int xc;
    bit p;
    wr_t w;
    bit bad;
    n16 = 16'(n_hdr);
    bad = (flip != 8'd0);
    x = 8'd0;
    do_start();
    send_byte(n16[7:0], pick_gap(maxgap, 0), 1'b0, xc);
    send_byte(n16[15:8], pick_gap(maxgap, 0), 1'b0, xc);
    if (n_hdr > DEPTH) begin
      chk("ovf_error", 32'(error), 1);
      chk("ovf_ready", 32'(bus.in_ready), 0);
      repeat (3) begin @(posedge clk); #1; end
      chk("ovf_error_sticky", 32'(error), 1);
      chk("ovf_busy", 32'(busy), 0);
      chk("ovf_cpu_rst", 32'(cpu_rst_n), 0);
      return;
    end
    for (int i = 0; i < n_hdr; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[i][8*k +: 8];
        x = x ^ b;
        p = bstart && (i == 0) && (k == 2);
        send_byte(b, pick_gap(maxgap, p), p, xc);
        if (k == 3) begin
          w.a = ADDR_W'(i);
          w.d = img[i];
          w.c = xc;
          exp_q.push_back(w);
        end
      end
    end
    send_byte(x ^ flip, pick_gap(maxgap, 0), 1'b0, xc);
    chk("end_done", 32'(done), bad ? 0 : 1);
    chk("end_error", 32'(error), bad ? 1 : 0);
    chk("end_cpu_rst", 32'(cpu_rst_n), bad ? 0 : 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("end_pending", 32'(exp_q.size()), 0);
  endtask

  task automatic set_nominal;
    img.delete();
    img.push_back(32'h00f707b3);
    img.push_back(32'hfe010113);
  endtask

  task automatic set_random(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst_n), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int xc;
    int n;
    bus.in_data  = 8'd0;
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_nominal();
    run_load(2, 8'h00, 0, 1'b0);
    run_load(2, 8'h01, 0, 1'b0);
    run_load(16'h0081, 8'h00, 0, 1'b0);
    run_load(2, 8'h00, 3, 1'b1);
    set_random(0);
    run_load(0, 8'h00, 0, 1'b0);

    // Mid-load reset: header plus three data bytes, then asynchronous reset.
    set_nominal();
    run_load(2, 8'h00, 0, 1'b0);
    do_start();
    send_byte(8'h02, 0, 1'b0, xc);
    send_byte(8'h00, 0, 1'b0, xc);
    send_byte(8'hb3, 0, 1'b0, xc);
    send_byte(8'h07, 0, 1'b0, xc);
    send_byte(8'hf7, 0, 1'b0, xc);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_load(2, 8'h00, 1, 1'b0);

    set_random(DEPTH);
    run_load(DEPTH, 8'h00, 0, 1'b0);

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        run_load(int'($urandom_range(DEPTH + 1, 65535)), 8'h00, 1, 1'b0);
      end else begin
        n = int'($urandom_range(0, 6));
        set_random(n);
        run_load(n, ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00,
                 int'($urandom_range(0, 3)), n > 0 && $urandom_range(0, 1) == 1);
      end
    end

    repeat (4) begin @(posedge clk); #1; end
    chk("final_pending", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills the instruction memory over a byte stream. It accepts a length-prefixed, checksum-terminated little-endian image and assembles it into 32-bit words. It drives the instruction memory write port and holds the CPU pipeline in reset until a valid image has been written. It sits between the host byte link (UART receiver or testbench driver) and the write side of the instruction memory.

## Interface
- DEPTH, 128: instruction memory size in 32-bit words; maximum accepted word count.
- ADDR_W, 7: width of wr_addr; must satisfy 2^ADDR_W >= DEPTH.
- BOOT_HOLD, 1: reset value of cpu_rst_n is 0 when 1, and 1 when 0 (use 0 for images preloaded from file).

- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only when not busy.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  ADDR_W  word index (byte PC = 4*wr_addr).
- wr_data  out  32  assembled instruction word.
- busy  out  1  load in progress.
- done  out  1  last load succeeded; sticky until next start or reset.
- error  out  1  last load failed; sticky until next start or reset.
- cpu_rst_n  out  1  active-low reset to the CPU core.

## Operation
- Stream format: CNT_LO, CNT_HI (16-bit word count N), then 4*N data bytes with each word least-significant byte first, then one CHK byte equal to the XOR of all data bytes (header excluded).
- States: IDLE, CNT_LO, CNT_HI, DATA, CHK, DONE, ERR. Reset goes to IDLE.
- IDLE/DONE/ERR on start: clear done, error, byte/word counters and running XOR; drive cpu_rst_n=0 and busy=1; go to CNT_LO.
- CNT_LO: latch low count byte, then go to CNT_HI.
- CNT_HI: latch the high byte.
  - If N > DEPTH, go to ERR.
  - If N == 0, go to CHK.
  - Otherwise go to DATA.
- DATA: shift each byte into the word at position (byte_idx mod 4) and XOR it into the running checksum. On the 4th byte, issue a write of the word at the current word index and increment the index. After word N-1 is written, go to CHK.
- CHK: on transfer, compare the byte with the running XOR. Match goes to DONE (done=1, cpu_rst_n=1); mismatch goes to ERR (error=1, cpu_rst_n stays 0).
- in_ready=1 only in CNT_LO, CNT_HI, DATA and CHK. busy=1 in those states.
- start while busy is ignored. in_valid outside the receiving states is ignored (no transfer).
- Words already written before an error are not rolled back.
- Word index never exceeds N-1 ≤ DEPTH-1. No wrap-around is possible because N is checked against DEPTH first.

## Timing
- Reset values:
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - busy=0, done=0, error=0.
  - cpu_rst_n = !BOOT_HOLD.
- All outputs are registered.
- start sampled at edge t gives busy=1, in_ready=1 and cpu_rst_n=0 from t+1.
- Write latency: if the 4th byte of word i transfers at edge t, then wr_en=1 with wr_addr=i and wr_data valid during the cycle after t, for exactly one cycle.
- Throughput is one byte per cycle with no internal stalls. in_valid gaps only delay progress.
- CHK transfer at edge t: done or error plus cpu_rst_n update are visible after t. in_ready=0 from t+1.
- Over-count: error=1 and in_ready=0 in the cycle after the CNT_HI transfer, and wr_en never asserts.
- rst_n low at any time, including mid-word or mid-write, asynchronously forces every output to its reset value and the state to IDLE. A partial word is discarded.

## Test plan
- Nominal load: start, then bytes 02 00 b3 07 f7 00 13 01 01 fe AE. Expect a write of addr0=0x00f707b3, then addr1=0xfe010113, each one cycle after its 4th byte. Then done=1, cpu_rst_n=1, error=0, busy=0.
- Bad checksum: same stream with last byte AF. Expect both writes to occur, then error=1, done=0, cpu_rst_n=0.
- Over-count: DEPTH=128, stream 81 00. Expect error=1 after the second byte, no wr_en ever, and in_ready=0.
- Backpressure and empty image: nominal stream with in_valid deasserted for 1–3 random cycles between bytes gives identical writes and done. Stream 00 00 00 gives done=1 with no writes.
- Reset mid-load: assert rst_n=0 after 5 bytes. Expect all outputs at reset values immediately. Restarting with the nominal stream completes correctly at addr0/addr1.
- start pulsed while busy is ignored (load unaffected). start pulsed in DONE clears done, drops cpu_rst_n and accepts a new image.
